// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Holds operand/result widths, the FSM state type and the circular
// priority search used by the round-robin arbiter.
package mult_share_pkg;

    localparam int OPERAND_W = 32;
    localparam int RESULT_W  = 64;

    // Upper bound on requester count supported by the priority search.
    localparam int MAX_REQ   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // First set bit of valid (among the low n bits) found by walking
    // circularly upward from ptr. Returns -1 when no bit is set.
    function automatic int rr_search(input logic [MAX_REQ-1:0] valid,
                                     input int ptr,
                                     input int n);
        int sel;
        int k;
        sel = -1;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int off = MAX_REQ - 1; off >= 0; off--) begin
            if (off < n) begin
                k = ptr + off;
                if (k >= n) begin
                    k = k - n;
                end
                if (valid[k]) begin
                    sel = k;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin grant selection: picks the first valid requester at or after
// rr_ptr (circularly) and flags whether any requester is valid.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
)
(
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_found_o
);

    int sel;

    // Circular search, then narrow the integer index to the ID width.
    always_comb begin
        sel         = rr_search(MAX_REQ'(req_valid_i), int'(rr_ptr_i), NUM_REQ);
        gnt_found_o = (sel >= 0);
        gnt_idx_o   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel == k) begin
                gnt_idx_o = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/tree_multiplier_csa.sv
// Combinational 32x32 -> 64 unsigned multiplier.
// Partial products are folded with 3:2 carry-save compressors so only one
// carry-propagate adder sits at the end. The sum stays exact because the
// product never exceeds 64 bits, so carries shifted out of bit 63 are zero
// in the true result.
module tree_multiplier_csa
    import mult_share_pkg::*;
(
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    output logic [RESULT_W-1:0]  p_o
);

    logic [RESULT_W-1:0] sum_v;
    logic [RESULT_W-1:0] carry_v;
    logic [RESULT_W-1:0] pp_v;
    logic [RESULT_W-1:0] tmp_v;

    // Carry-save reduction of all partial products, then a final add.
    always_comb begin
        sum_v   = '0;
        carry_v = '0;
        pp_v    = '0;
        tmp_v   = '0;
        for (int i = 0; i < OPERAND_W; i++) begin
            pp_v    = b_i[i] ? ({{(RESULT_W-OPERAND_W){1'b0}}, a_i} << i) : '0;
            tmp_v   = sum_v ^ carry_v ^ pp_v;
            carry_v = ((sum_v & carry_v) | (sum_v & pp_v) | (carry_v & pp_v)) << 1;
            sum_v   = tmp_v;
        end
        p_o = sum_v + carry_v;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational 32x32 multiplier between NUM_REQ requesters.
// Requests are granted round-robin; the winning operands are registered and
// held for MULT_CYCLES cycles (multicycle path through the multiplier) before
// the product is captured and presented on a single response channel tagged
// with the requester index.
// Optional build macro MULT_SHARE_ZERO_BYPASS_EN: a zero operand skips the
// multicycle wait and the zero result is presented right after acceptance.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MULT_CYCLES = 4,
    parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*OPERAND_W-1:0]   req_a,
    input  logic [NUM_REQ*OPERAND_W-1:0]   req_b,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [RESULT_W-1:0]            resp_result,
    output logic [ID_W-1:0]                resp_id,
    output logic                           busy
);

    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [OPERAND_W-1:0] reg_a_q, reg_a_d;
    logic [OPERAND_W-1:0] reg_b_q, reg_b_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [RESULT_W-1:0]  resp_result_q, resp_result_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;

    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_found;
    logic                 accept;
    logic [OPERAND_W-1:0] sel_a;
    logic [OPERAND_W-1:0] sel_b;
    logic [ID_W-1:0]      ptr_next;
    logic [RESULT_W-1:0]  product;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_found_o (gnt_found)
    );

    // Only the held operand registers feed the multiplier, so its inputs are
    // stable for the whole multicycle window.
    tree_multiplier_csa u_mult (
        .a_i (reg_a_q),
        .b_i (reg_b_q),
        .p_o (product)
    );

    assign accept    = (state_q == IDLE) && gnt_found;
    assign sel_a     = req_a[int'(gnt_idx)*OPERAND_W +: OPERAND_W];
    assign sel_b     = req_b[int'(gnt_idx)*OPERAND_W +: OPERAND_W];
    assign ptr_next  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);

    // req_ready is masked while reset is held so nothing looks accepted.
    assign req_ready   = (accept && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign busy        = (state_q != IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_id     = resp_id_q;

    // Next-state and datapath register updates for IDLE/WAIT/DONE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        reg_a_d       = reg_a_q;
        reg_b_d       = reg_b_q;
        id_d          = id_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_id_d     = resp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    reg_a_d  = sel_a;
                    reg_b_d  = sel_b;
                    id_d     = gnt_idx;
                    rr_ptr_d = ptr_next;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        resp_result_d = '0;
                        resp_id_d     = gnt_idx;
                        resp_valid_d  = 1'b1;
                        state_d       = DONE;
                    end else begin
                        cnt_d   = CNT_W'(MULT_CYCLES - 1);
                        state_d = WAIT;
                    end
`else
                    cnt_d   = CNT_W'(MULT_CYCLES - 1);
                    state_d = WAIT;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    resp_result_d = product;
                    resp_id_d     = id_q;
                    resp_valid_d  = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            reg_a_q       <= '0;
            reg_b_q       <= '0;
            id_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            reg_a_q       <= reg_a_d;
            reg_b_q       <= reg_b_d;
            id_q          <= id_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_id_q     <= resp_id_d;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter (NUM_REQ=4, MULT_CYCLES=4).
// A transaction-level model (queue of outstanding products with due cycles
// and a round-robin pointer) is checked against the DUT every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int MC  = 4;
    localparam int IDW = 2;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a = '0;
    logic [N*32-1:0]   req_b = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [63:0]       resp_result;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NUM_REQ     (N),
        .MULT_CYCLES (MC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_id     (resp_id),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct { int id; logic [63:0] res; int due; } exp_t;
    typedef struct { int id; int cyc; } acc_t;
    typedef struct { int id; logic [63:0] res; int cyc; } rsp_t;

    exp_t q[$];
    acc_t acc_log[$];
    rsp_t rsp_log[$];
    int   cyc   = 0;
    int   m_ptr = 0;
    logic prev_rv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Model: one outstanding operation at a time; idle means nothing queued.
    always @(posedge clk) begin : model
        int          g;
        int          now;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        acc_t        ac;
        now = cyc + 1;
        if (rst) begin
            q.delete();
            m_ptr = 0;
        end else if (q.size() != 0) begin
            if (cyc >= q[0].due && resp_ready) q.pop_front();
        end else begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                a     = req_a[g*32 +: 32];
                b     = req_b[g*32 +: 32];
                lat   = (BYP && (a == 0 || b == 0)) ? 0 : MC;
                e.id  = g;
                e.res = {32'b0, a} * {32'b0, b};
                e.due = now + lat;
                q.push_back(e);
                ac.id  = g;
                ac.cyc = now;
                acc_log.push_back(ac);
                m_ptr = (g + 1) % N;
            end
        end
        cyc = now;
    end

    // Compare DUT against the model on the falling edge.
    always @(negedge clk) begin : cmp
        logic [N-1:0] er;
        logic         erv;
        int           g;
        rsp_t         r;
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_result", resp_result, 64'd0);
            chk("rst_resp_id", 64'(resp_id), 64'd0);
        end else begin
            erv = (q.size() != 0) && (cyc >= q[0].due);
            er  = '0;
            if (q.size() == 0) begin
                g = pick(req_valid, m_ptr);
                if (g >= 0) er[g] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            chk("busy", 64'(busy), 64'(q.size() != 0));
            chk("resp_valid", 64'(resp_valid), 64'(erv));
            if (erv) begin
                chk("resp_result", resp_result, q[0].res);
                chk("resp_id", 64'(resp_id), 64'(q[0].id));
            end
            if (resp_valid && !prev_rv) begin
                r.id  = int'(resp_id);
                r.res = resp_result;
                r.cyc = cyc;
                rsp_log.push_back(r);
            end
        end
        prev_rv = resp_valid;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_acc(input int target, input string nm);
        int t;
        t = 0;
        while (acc_log.size() < target && t < 200) begin
            step();
            t++;
        end
        n_vec++;
        if (acc_log.size() < target) begin
            n_err++;
            $display("FAIL %s: accept timeout, got %0d accepts, required %0d", nm, acc_log.size(), target);
        end
    endtask

    task automatic wait_rsp(input int target, input string nm);
        int t;
        t = 0;
        while (rsp_log.size() < target && t < 200) begin
            step();
            t++;
        end
        n_vec++;
        if (rsp_log.size() < target) begin
            n_err++;
            $display("FAIL %s: response timeout, got %0d responses, required %0d", nm, rsp_log.size(), target);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int na;
        int nr;
        int c_raise;
        int exp_ids [5];
        logic [63:0] exp_res [5];

        // Reset state
        rst = 1'b1;
        step(3);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        step(2);

        // 3 * 5 from requester 0
        na = acc_log.size(); nr = rsp_log.size();
        set_req(0, 32'd3, 32'd5);
        wait_acc(na + 1, "t1_acc");
        req_valid[0] = 1'b0;
        wait_rsp(nr + 1, "t1_rsp");
        if (rsp_log.size() > nr && acc_log.size() > na) begin
            chk("t1_result", rsp_log[nr].res, 64'd15);
            chk("t1_id", 64'(rsp_log[nr].id), 64'd0);
            chk("t1_latency", 64'(rsp_log[nr].cyc - acc_log[na].cyc), 64'(MC));
        end
        step(3);

        // Max operands from requester 2
        na = acc_log.size(); nr = rsp_log.size();
        set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_acc(na + 1, "t2_acc");
        req_valid[2] = 1'b0;
        wait_rsp(nr + 1, "t2_rsp");
        if (rsp_log.size() > nr) begin
            chk("t2_result", rsp_log[nr].res, 64'hFFFF_FFFE_0000_0001);
            chk("t2_id", 64'(rsp_log[nr].id), 64'd2);
        end
        step(3);

        // All four requesters held valid from reset
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'(10 * (i + 1)), 32'(i + 2));
        step(2);
        na = acc_log.size(); nr = rsp_log.size();
        rst = 1'b0;
        wait_acc(na + 5, "t3_acc");
        req_valid = '0;
        wait_rsp(nr + 5, "t3_rsp");
        exp_ids = '{0, 1, 2, 3, 0};
        exp_res = '{64'd20, 64'd60, 64'd120, 64'd200, 64'd20};
        if (rsp_log.size() >= nr + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t3_order%0d", k), 64'(rsp_log[nr + k].id), 64'(exp_ids[k]));
                chk($sformatf("t3_result%0d", k), rsp_log[nr + k].res, exp_res[k]);
            end
        end
        step(3);

        // Consumer stalls for 10 cycles in DONE
        resp_ready = 1'b0;
        na = acc_log.size(); nr = rsp_log.size();
        set_req(1, 32'd6, 32'd7);
        wait_acc(na + 1, "t4_acc");
        req_valid[1] = 1'b0;
        set_req(3, 32'd9, 32'd9);
        wait_rsp(nr + 1, "t4_rsp");
        step(10);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_resp_valid", 64'(resp_valid), 64'd1);
        chk("t4_result_hold", resp_result, 64'd42);
        chk("t4_id_hold", 64'(resp_id), 64'd1);
        chk("t4_req_ready", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        c_raise = cyc;
        na = acc_log.size(); nr = rsp_log.size();
        wait_acc(na + 1, "t4_next_acc");
        req_valid[3] = 1'b0;
        if (acc_log.size() > na) begin
            chk("t4_next_id", 64'(acc_log[na].id), 64'd3);
            chk("t4_next_edge", 64'(acc_log[na].cyc - c_raise), 64'd2);
        end
        wait_rsp(nr + 1, "t4_next_rsp");
        if (rsp_log.size() > nr) chk("t4_next_result", rsp_log[nr].res, 64'd81);
        step(3);

        // Reset during WAIT discards the operation
        na = acc_log.size();
        set_req(2, 32'd11, 32'd13);
        wait_acc(na + 1, "t5_acc");
        req_valid[2] = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
        chk("t5_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("t5_rst_resp_result", resp_result, 64'd0);
        chk("t5_rst_resp_id", 64'(resp_id), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        step(2);
        rst = 1'b0;
        nr = rsp_log.size();
        step(10);
        chk("t5_no_resp", 64'(rsp_log.size()), 64'(nr));
        na = acc_log.size();
        set_req(0, 32'd7, 32'd9);
        set_req(3, 32'd2, 32'd2);
        wait_acc(na + 1, "t5_acc2");
        req_valid[0] = 1'b0;
        wait_rsp(nr + 1, "t5_rsp");
        if (rsp_log.size() > nr) begin
            chk("t5_result", rsp_log[nr].res, 64'd63);
            chk("t5_id", 64'(rsp_log[nr].id), 64'd0);
        end
        wait_acc(na + 2, "t5_acc3");
        req_valid[3] = 1'b0;
        wait_rsp(nr + 2, "t5_rsp3");
        if (rsp_log.size() > nr + 1) chk("t5_result3", rsp_log[nr + 1].res, 64'd4);
        step(3);

        // Zero operand
        na = acc_log.size(); nr = rsp_log.size();
        set_req(1, 32'd0, 32'd7);
        wait_acc(na + 1, "t6_acc");
        req_valid[1] = 1'b0;
        wait_rsp(nr + 1, "t6_rsp");
        if (rsp_log.size() > nr && acc_log.size() > na) begin
            chk("t6_result", rsp_log[nr].res, 64'd0);
            chk("t6_id", 64'(rsp_log[nr].id), 64'd1);
            chk("t6_latency", 64'(rsp_log[nr].cyc - acc_log[na].cyc), BYP ? 64'd0 : 64'(MC));
        end
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
